ddr_cmd_dly_ctrl: RTL and testbench

- Controls the output delay line of one DDR3 address/command IOD lane (e.g. CS0_N): drives DELAY_LINE_LOAD/MOVE/DIRECTION, monitors DELAY_LINE_OUT_OF_RANGE.
- Sits directly upstream of the lane's IOD wrapper, in the FAB_CLK domain.
- Accepts a target tap from the training/calibration logic, walks the delay line one tap per move, tracks the current tap, and reports completion or error.

---
 rtl/ddr_cmd_dly_pkg.sv | 16 +
 rtl/ddr_cmd_dly_settle_cnt.sv | 27 ++
 rtl/ddr_cmd_dly_ctrl.sv | 136 +++++++++++++
 tb/tb_ddr_cmd_dly_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/ddr_cmd_dly_pkg.sv
// rtl/ddr_cmd_dly_pkg.sv - shared state encoding and direction constants for the DDR command delay controller
package ddr_cmd_dly_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CMP,
    MOVE,
    SETTLE,
    FIN
  } state_t;

  localparam logic DIR_INC = 1'b1;
  localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/ddr_cmd_dly_settle_cnt.sv
// rtl/ddr_cmd_dly_settle_cnt.sv - loadable down-counter with zero flag timing the delay-line settle window
module ddr_cmd_dly_settle_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/ddr_cmd_dly_ctrl.sv
// rtl/ddr_cmd_dly_ctrl.sv - walks one IOD output delay line to a requested tap; DDR_CMD_DLY_MOVE_CNT_EN adds MOVE_CNT
module ddr_cmd_dly_ctrl
  import ddr_cmd_dly_pkg::*;
#(
  parameter int TAP_W      = 8,
  parameter int INIT_TAP   = 1,
  parameter int MAX_TAP    = 255,
  parameter int SETTLE_CYC = 4
) (
  input  logic             FAB_CLK,
  input  logic             TX_SYNC_RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [TAP_W-1:0] REQ_TAP,
  input  logic             REQ_RELOAD,
  output logic             DONE,
  output logic             ERR,
  output logic [TAP_W-1:0] CUR_TAP,
  output logic             DELAY_LINE_LOAD_0,
  output logic             DELAY_LINE_MOVE_0,
  output logic             DELAY_LINE_DIRECTION_0,
`ifdef DDR_CMD_DLY_MOVE_CNT_EN
  output logic [15:0]      MOVE_CNT,
`endif
  input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

  localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [TAP_W:0]   MAX_EXT   = (TAP_W + 1)'(MAX_TAP);
  localparam logic [TAP_W-1:0] MAX_T     = TAP_W'(MAX_TAP);
  localparam logic [TAP_W-1:0] INIT_T    = TAP_W'(INIT_TAP);

  state_t           state;
  logic [TAP_W-1:0] target;
  logic             after_move;
  logic             oor_seen;
  logic             settle_zero;
  logic             over_max;

  // Extra bit keeps the clamp compare meaningful when MAX_TAP is the full TAP_W range.
  assign over_max  = ({1'b0, REQ_TAP} > MAX_EXT);
  assign REQ_READY = (state == IDLE);

  ddr_cmd_dly_settle_cnt #(.W(CNT_W)) u_settle_cnt (
    .clk      (FAB_CLK),
    .rst      (TX_SYNC_RST),
    .load     ((state == LOAD) || (state == MOVE)),
    .load_val (SETTLE_LD),
    .dec      (state == SETTLE),
    .zero     (settle_zero)
  );

  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      state                  <= IDLE;
      CUR_TAP                <= INIT_T;
      target                 <= INIT_T;
      ERR                    <= 1'b0;
      DONE                   <= 1'b0;
      DELAY_LINE_LOAD_0      <= 1'b0;
      DELAY_LINE_MOVE_0      <= 1'b0;
      DELAY_LINE_DIRECTION_0 <= 1'b0;
      after_move             <= 1'b0;
      oor_seen               <= 1'b0;
    end else begin
      DONE              <= 1'b0;
      DELAY_LINE_LOAD_0 <= 1'b0;
      DELAY_LINE_MOVE_0 <= 1'b0;
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            ERR    <= over_max;
            target <= over_max ? MAX_T : REQ_TAP;
            if (REQ_RELOAD) begin
              state             <= LOAD;
              DELAY_LINE_LOAD_0 <= 1'b1;
            end else begin
              state <= CMP;
            end
          end
        end
        LOAD: begin
          CUR_TAP    <= INIT_T;
          after_move <= 1'b0;
          state      <= SETTLE;
        end
        CMP: begin
          if (target == CUR_TAP) begin
            state <= FIN;
            DONE  <= 1'b1;
          end else begin
            DELAY_LINE_DIRECTION_0 <= (target > CUR_TAP) ? DIR_INC : DIR_DEC;
            DELAY_LINE_MOVE_0      <= 1'b1;
            state                  <= MOVE;
          end
        end
        MOVE: begin
          after_move <= 1'b1;
          oor_seen   <= 1'b0;
          state      <= SETTLE;
        end
        SETTLE: begin
          if (DELAY_LINE_OUT_OF_RANGE_0) oor_seen <= 1'b1;
          if (settle_zero) begin
            // An out-of-range flag means the IOD refused the step, so the tap is left as it was.
            if (after_move && (oor_seen || DELAY_LINE_OUT_OF_RANGE_0)) begin
              ERR   <= 1'b1;
              DONE  <= 1'b1;
              state <= FIN;
            end else begin
              if (after_move) begin
                CUR_TAP <= (DELAY_LINE_DIRECTION_0 == DIR_INC) ? CUR_TAP + TAP_W'(1)
                                                               : CUR_TAP - TAP_W'(1);
              end
              state <= CMP;
            end
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DDR_CMD_DLY_MOVE_CNT_EN
  always_ff @(posedge FAB_CLK) begin
    if (TX_SYNC_RST) begin
      MOVE_CNT <= 16'h0000;
    end else if (DELAY_LINE_MOVE_0 && (MOVE_CNT != 16'hFFFF)) begin
      MOVE_CNT <= MOVE_CNT + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_ddr_cmd_dly_ctrl.sv
// tb/tb_ddr_cmd_dly_ctrl.sv - directed vector bench for ddr_cmd_dly_ctrl (default and MAX_TAP=10 instances)
module tb_ddr_cmd_dly_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, req_valid, sel, req_reload, oor;
  logic [7:0] req_tap;

  logic       ready_a, done_a, err_a, load_a, move_a, dir_a;
  logic       ready_b, done_b, err_b, load_b, move_b, dir_b;
  logic [7:0] cur_a, cur_b;
`ifdef DDR_CMD_DLY_MOVE_CNT_EN
  logic [15:0] mcnt_a, mcnt_b;
`endif

  ddr_cmd_dly_ctrl u_dut (
    .FAB_CLK                   (clk),
    .TX_SYNC_RST               (rst),
    .REQ_VALID                 (req_valid & ~sel),
    .REQ_READY                 (ready_a),
    .REQ_TAP                   (req_tap),
    .REQ_RELOAD                (req_reload),
    .DONE                      (done_a),
    .ERR                       (err_a),
    .CUR_TAP                   (cur_a),
    .DELAY_LINE_LOAD_0         (load_a),
    .DELAY_LINE_MOVE_0         (move_a),
    .DELAY_LINE_DIRECTION_0    (dir_a),
`ifdef DDR_CMD_DLY_MOVE_CNT_EN
    .MOVE_CNT                  (mcnt_a),
`endif
    .DELAY_LINE_OUT_OF_RANGE_0 (oor)
  );

  ddr_cmd_dly_ctrl #(.MAX_TAP(10)) u_dut_clamp (
    .FAB_CLK                   (clk),
    .TX_SYNC_RST               (rst),
    .REQ_VALID                 (req_valid & sel),
    .REQ_READY                 (ready_b),
    .REQ_TAP                   (req_tap),
    .REQ_RELOAD                (req_reload),
    .DONE                      (done_b),
    .ERR                       (err_b),
    .CUR_TAP                   (cur_b),
    .DELAY_LINE_LOAD_0         (load_b),
    .DELAY_LINE_MOVE_0         (move_b),
    .DELAY_LINE_DIRECTION_0    (dir_b),
`ifdef DDR_CMD_DLY_MOVE_CNT_EN
    .MOVE_CNT                  (mcnt_b),
`endif
    .DELAY_LINE_OUT_OF_RANGE_0 (1'b0)
  );

  logic       ready_s, done_s, err_s, load_s, move_s, dir_s;
  logic [7:0] cur_s;
  assign ready_s = sel ? ready_b : ready_a;
  assign done_s  = sel ? done_b  : done_a;
  assign err_s   = sel ? err_b   : err_a;
  assign load_s  = sel ? load_b  : load_a;
  assign move_s  = sel ? move_b  : move_a;
  assign dir_s   = sel ? dir_b   : dir_a;
  assign cur_s   = sel ? cur_b   : cur_a;

  typedef struct {
    logic       rl;
    logic [7:0] tap;
    int         lat;
    int         moves;
    int         loads;
    int         cur;
    int         err;
    int         dir;
  } vec_t;

  vec_t vecs [5];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Issues one request and follows it to DONE, counting pulses and protocol violations.
  task automatic run_req(input logic rl, input logic [7:0] tap, input int oor_move,
                         output int lat, output int moves, output int loads, output int err_acc);
    int viol;
    logic prev_move, arm;
    @(negedge clk);
    check("ready_before_req", ready_s, 1);
    req_valid = 1'b1; req_tap = tap; req_reload = rl;
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1; moves = 0; loads = 0; viol = 0; prev_move = 1'b0; arm = 1'b0;
    err_acc = err_s;
    while (!done_s && lat < 400) begin
      oor = arm; arm = 1'b0;
      if (move_s && load_s) viol++;
      if (move_s && prev_move) viol++;
      prev_move = move_s;
      loads += int'(load_s);
      if (move_s) begin
        moves++;
        if (moves == oor_move) arm = 1'b1;
      end
      @(negedge clk);
      lat++;
    end
    oor = 1'b0;
    check("done_seen", int'(done_s), 1);
    check("pulse_rules", viol, 0);
  endtask

  int lat, moves, loads, err_acc, dones, guard;

  initial begin
    vecs[0] = '{1'b0, 8'd5, 26, 4, 0, 5, 0, 1};
    vecs[1] = '{1'b1, 8'd2, 13, 1, 1, 2, 0, 1};
    vecs[2] = '{1'b0, 8'd2,  2, 0, 0, 2, 0, 1};
    vecs[3] = '{1'b0, 8'd0, 14, 2, 0, 0, 0, 0};
    vecs[4] = '{1'b1, 8'd1,  7, 0, 1, 1, 0, 0};

    rst = 1'b1; req_valid = 1'b0; sel = 1'b0; req_reload = 1'b0; req_tap = '0; oor = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_cur",   cur_a, 1);
    check("rst_err",   err_a, 0);
    check("rst_done",  done_a, 0);
    check("rst_load",  load_a, 0);
    check("rst_move",  move_a, 0);
    check("rst_dir",   dir_a, 0);
    check("rst_ready", ready_a, 1);
    check("rst_cur_b", cur_b, 1);
`ifdef DDR_CMD_DLY_MOVE_CNT_EN
    check("rst_move_cnt", mcnt_a, 0);
`endif

    for (int i = 0; i < 5; i++) begin
      run_req(vecs[i].rl, vecs[i].tap, 0, lat, moves, loads, err_acc);
      check($sformatf("v%0d_lat", i),   lat,    vecs[i].lat);
      check($sformatf("v%0d_moves", i), moves,  vecs[i].moves);
      check($sformatf("v%0d_loads", i), loads,  vecs[i].loads);
      check($sformatf("v%0d_cur", i),   cur_s,  vecs[i].cur);
      check($sformatf("v%0d_err", i),   err_s,  vecs[i].err);
      check($sformatf("v%0d_dir", i),   dir_s,  vecs[i].dir);
    end

    // Range flag during the settle after the 3rd move from tap 1: walk stops at tap 3.
    run_req(1'b0, 8'd20, 3, lat, moves, loads, err_acc);
    check("oor_lat",   lat, 19);
    check("oor_moves", moves, 3);
    check("oor_cur",   cur_a, 3);
    check("oor_err",   err_a, 1);

    run_req(1'b0, 8'd3, 0, lat, moves, loads, err_acc);
    check("err_clear_lat", lat, 2);
    check("err_clear_err", err_a, 0);
    check("err_clear_cur", cur_a, 3);
`ifdef DDR_CMD_DLY_MOVE_CNT_EN
    check("move_cnt_total", mcnt_a, 10);
`endif

    sel = 1'b1;
    run_req(1'b0, 8'd200, 0, lat, moves, loads, err_acc);
    check("clamp_err_accept", err_acc, 1);
    check("clamp_moves", moves, 9);
    check("clamp_lat",   lat, 56);
    check("clamp_cur",   cur_b, 10);
    check("clamp_err",   err_b, 1);
    sel = 1'b0;

    // Reset in the middle of a settle window.
    @(negedge clk);
    req_valid = 1'b1; req_tap = 8'd10; req_reload = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    guard = 0;
    while (!move_a && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("mid_move_seen", int'(move_a), 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_cur",   cur_a, 1);
    check("mid_rst_move",  move_a, 0);
    check("mid_rst_load",  load_a, 0);
    check("mid_rst_ready", ready_a, 1);
    check("mid_rst_done",  done_a, 0);
`ifdef DDR_CMD_DLY_MOVE_CNT_EN
    check("mid_rst_move_cnt", mcnt_a, 0);
`endif
    rst = 1'b0;
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      dones += int'(done_a);
    end
    check("mid_rst_no_done", dones, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
